// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM states, mul_signed mode codes and Booth digit
// decoding for the sequential radix-4 Booth multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // mul_signed encodings; 2'b01 is treated like MUL_UU.
  localparam logic [1:0] MUL_SS = 2'b11;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_UU = 2'b00;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_M1   = 3'd3,
    DIG_M2   = 3'd4
  } booth_dig_e;

  // Radix-4 Booth recoding of the window {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_dig_e booth_decode(input logic [2:0] win);
    booth_dig_e dig;
    case (win)
      3'b001, 3'b010: dig = DIG_P1;
      3'b011:         dig = DIG_P2;
      3'b100:         dig = DIG_M2;
      3'b101, 3'b110: dig = DIG_M1;
      default:        dig = DIG_ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: one radix-4 Booth digit applied to the (already extended and
// aligned) multiplicand, giving a two's-complement partial product.
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int unsigned PW = 128
) (
  input  logic [2:0]    i_win,
  input  logic [PW-1:0] i_mcand,
  output logic [PW-1:0] o_pp
);

  booth_dig_e w_dig;

  // Decode the window and select {-2,-1,0,+1,+2} x multiplicand.
  always_comb begin
    w_dig = booth_decode(i_win);
    case (w_dig)
      DIG_P1:  o_pp = i_mcand;
      DIG_P2:  o_pp = i_mcand << 1;
      DIG_M1:  o_pp = -i_mcand;
      DIG_M2:  o_pp = -(i_mcand << 1);
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mul_seq.sv
// booth_radix4_mul_seq: iterative radix-4 Booth multiplier, DPC digits per
// BUSY cycle, valid/ready on both sides, flush, RV64M MUL* and MULW forms.
// Optional build macro: MUL_ZERO_BYPASS_EN (zero operand skips BUSY).
module booth_radix4_mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned DPC  = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int unsigned HW       = XLEN / 2;
  // Only product bits [2*XLEN-1:0] are observable, so the accumulator and the
  // shifted multiplicand are kept modulo 2^(2*XLEN).
  localparam int unsigned PW       = 2 * XLEN;
  // Multiplier register: bit 0 is Booth bit -1, then W+2 extended bits.
  localparam int unsigned MW       = XLEN + 3;
  localparam int unsigned CYC_FULL = (XLEN / 2 + DPC) / DPC;
  localparam int unsigned CYC_WORD = (XLEN / 4 + DPC) / DPC;
  localparam int unsigned CW       = $clog2(CYC_FULL) + 1;

  mul_state_e      r_state;
  mul_state_e      w_state_nxt;
  logic            w_accept;
  logic            w_finish;
  logic            w_bypass;

  logic [PW-1:0]   r_mcand;
  logic [MW-1:0]   r_mplier;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_mulw;
  logic [XLEN-1:0] r_res_hi;
  logic [XLEN-1:0] r_res_lo;

  logic            w_sa;
  logic            w_sb;
  logic [PW-1:0]   w_a_ext;
  logic [XLEN+1:0] w_b_ext;
  logic [PW-1:0]   w_pp [DPC];
  logic [PW-1:0]   w_acc_nxt;
  logic [XLEN-1:0] w_res_hi;
  logic [XLEN-1:0] w_res_lo;

  assign result_hi = r_res_hi;
  assign result_lo = r_res_lo;

  // Sign/zero-extend the effective operands (low half in word mode).
  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    if (mul_signed == MUL_SS || mul_signed == MUL_SU)
      w_sa = mulw ? multiplicand[HW-1] : multiplicand[XLEN-1];
    if (mul_signed == MUL_SS)
      w_sb = mulw ? multiplier[HW-1] : multiplier[XLEN-1];
    if (mulw) begin
      w_a_ext = {{(PW-HW){w_sa}}, multiplicand[HW-1:0]};
      w_b_ext = {{(XLEN+2-HW){w_sb}}, multiplier[HW-1:0]};
    end else begin
      w_a_ext = {{(PW-XLEN){w_sa}}, multiplicand};
      w_b_ext = {{2{w_sb}}, multiplier};
    end
  end

`ifdef MUL_ZERO_BYPASS_EN
  // Zero effective operand: product is known to be 0 without iterating.
  always_comb begin
    if (mulw)
      w_bypass = (multiplicand[HW-1:0] == '0) || (multiplier[HW-1:0] == '0);
    else
      w_bypass = (multiplicand == '0) || (multiplier == '0);
  end
`else
  // Every operation takes the full iterative latency.
  always_comb w_bypass = 1'b0;
`endif

  // DPC Booth digits per cycle; digit k sees the multiplicand shifted by 2k.
  for (genvar k = 0; k < DPC; k++) begin : g_pp
    logic [PW-1:0] w_mc_sh;
    assign w_mc_sh = r_mcand << (2 * k);
    booth_pp_gen #(.PW(PW)) u_pp (
      .i_win   (r_mplier[2*k+2 -: 3]),
      .i_mcand (w_mc_sh),
      .o_pp    (w_pp[k])
    );
  end

  // Accumulate this cycle's partial products.
  always_comb begin
    w_acc_nxt = r_acc;
    for (int unsigned k = 0; k < DPC; k++)
      w_acc_nxt = w_acc_nxt + w_pp[k];
  end

  // Format the final product; word mode sign-extends each W-bit half.
  always_comb begin
    if (r_mulw) begin
      w_res_lo = {{HW{w_acc_nxt[HW-1]}}, w_acc_nxt[HW-1:0]};
      w_res_hi = {{HW{w_acc_nxt[XLEN-1]}}, w_acc_nxt[XLEN-1:HW]};
    end else begin
      w_res_hi = w_acc_nxt[PW-1:XLEN];
      w_res_lo = w_acc_nxt[XLEN-1:0];
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          w_accept    = 1'b1;
          w_state_nxt = w_bypass ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand latch, iteration datapath, digit counter and result holding.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mulw   <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      if (w_accept) begin
        r_mcand  <= w_a_ext;
        r_mplier <= {w_b_ext, 1'b0};
        r_acc    <= '0;
        r_cnt    <= mulw ? CW'(CYC_WORD - 1) : CW'(CYC_FULL - 1);
        r_mulw   <= mulw;
      end else if (r_state == ST_BUSY) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << (2 * DPC);
        r_mplier <= {{(2*DPC){r_mplier[MW-1]}}, r_mplier[MW-1:2*DPC]};
        r_cnt    <= r_cnt - 1'b1;
      end
      if (w_finish) begin
        r_res_hi <= w_res_hi;
        r_res_lo <= w_res_lo;
      end else if (w_accept && w_bypass) begin
        r_res_hi <= '0;
        r_res_lo <= '0;
      end
    end
  end

endmodule
